// File: rtl/jtdsp16_sout_deser.sv
// Receiver for the DSP16 serial output port: rebuilds 16-bit words from sdo/ock/old/sadd,
// pairs left/right words and hands each pair to the mixer over a valid/ack handshake.
module jtdsp16_sout_deser #(
    parameter int MSB_FIRST = 1,
    parameter int TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        sdo,
    input  logic        ock,
    input  logic        old,
    input  logic        sadd,
    output logic        doen,
    output logic [15:0] left,
    output logic [15:0] right,
    output logic        sample_valid,
    input  logic        sample_ack,
    output logic        frame_err,
    output logic        overrun
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // synchroniser vector order: {sdo, ock, old, sadd}
    logic [3:0]    sync1_d, sync1_q;
    logic [3:0]    sync2_d, sync2_q;
    logic [1:0]    edge_d,  edge_q;

    logic          sdo_s;
    logic          sadd_s;
    logic          ock_rise_s;
    logic          old_rise_s;

    logic [1:0]    state_d,  state_q;
    logic [4:0]    cnt_d,    cnt_q;
    logic [TW-1:0] timer_d,  timer_q;
    logic [15:0]   shift_d,  shift_q;
    logic          chan_d,   chan_q;
    logic [15:0]   hold_l_d, hold_l_q;
    logic          pend_l_d, pend_l_q;
    logic [15:0]   left_d,   left_q;
    logic [15:0]   right_d,  right_q;
    logic          valid_d,  valid_q;
    logic          ferr_d,   ferr_q;
    logic          ovr_d,    ovr_q;
    logic          doen_d,   doen_q;

    logic          ferr_set_s;
    logic          ovr_set_s;
    logic          load_s;
    logic [15:0]   shift_in_s;

    // Synchroniser chain and edge-detect stage
    always_comb begin
        sync1_d = {sdo, ock, old, sadd};
        sync2_d = sync1_q;
        edge_d  = {sync2_q[2], sync2_q[1]};
    end

    assign sdo_s      = sync2_q[3];
    assign sadd_s     = sync2_q[0];
    assign ock_rise_s = sync2_q[2] & ~edge_q[1];
    assign old_rise_s = sync2_q[1] & ~edge_q[0];

    // Next shift-register value for one captured bit, in the configured bit order
    always_comb begin
        if (MSB_FIRST != 0) begin
            shift_in_s = {shift_q[14:0], sdo_s};
        end else begin
            shift_in_s = {sdo_s, shift_q[15:1]};
        end
    end

    // Receive FSM, pairing logic and output handshake
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        shift_d    = shift_q;
        chan_d     = chan_q;
        hold_l_d   = hold_l_q;
        pend_l_d   = pend_l_q;
        left_d     = left_q;
        right_d    = right_q;
        valid_d    = valid_q;
        ferr_d     = ferr_q;
        ovr_d      = ovr_q;
        doen_d     = enable;
        ferr_set_s = 1'b0;
        ovr_set_s  = 1'b0;
        load_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable && old_rise_s) begin
                    chan_d  = sadd_s;
                    shift_d = 16'h0000;
                    cnt_d   = 5'd0;
                    timer_d = {TW{1'b0}};
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (old_rise_s) begin
                    // a new word start mid-word aborts the old one and restarts at once
                    ferr_set_s = 1'b1;
                    chan_d     = sadd_s;
                    shift_d    = 16'h0000;
                    cnt_d      = 5'd0;
                    timer_d    = {TW{1'b0}};
                    state_d    = ST_SHIFT;
                end else if (ock_rise_s) begin
                    shift_d = shift_in_s;
                    cnt_d   = cnt_q + 5'd1;
                    timer_d = {TW{1'b0}};
                    if (cnt_q == 5'd15) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                    if (timer_q == TW'(TIMEOUT - 1)) begin
                        ferr_set_s = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (!enable) begin
                    pend_l_d = 1'b0;
                end else if (chan_q) begin
                    hold_l_d = shift_q;
                    pend_l_d = 1'b1;
                end else if (pend_l_q) begin
                    pend_l_d = 1'b0;
                    if (!valid_q || sample_ack) begin
                        load_s = 1'b1;
                    end else begin
                        ovr_set_s = 1'b1;
                    end
                end else begin
                    pend_l_d = pend_l_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!enable) begin
            pend_l_d = 1'b0;
        end else begin
            pend_l_d = pend_l_d;
        end

        if (load_s) begin
            left_d  = hold_l_q;
            right_d = shift_q;
            valid_d = 1'b1;
        end else if (valid_q && sample_ack) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        // a same-cycle set beats the ack clear
        if (ferr_set_s) begin
            ferr_d = 1'b1;
        end else if (sample_ack) begin
            ferr_d = 1'b0;
        end else begin
            ferr_d = ferr_q;
        end

        if (ovr_set_s) begin
            ovr_d = 1'b1;
        end else if (sample_ack) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 4'b0000;
            sync2_q  <= 4'b0000;
            edge_q   <= 2'b00;
            state_q  <= ST_IDLE;
            cnt_q    <= 5'd0;
            timer_q  <= {TW{1'b0}};
            shift_q  <= 16'h0000;
            chan_q   <= 1'b0;
            hold_l_q <= 16'h0000;
            pend_l_q <= 1'b0;
            left_q   <= 16'h0000;
            right_q  <= 16'h0000;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
            doen_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            edge_q   <= edge_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            shift_q  <= shift_d;
            chan_q   <= chan_d;
            hold_l_q <= hold_l_d;
            pend_l_q <= pend_l_d;
            left_q   <= left_d;
            right_q  <= right_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
            doen_q   <= doen_d;
        end
    end

    assign doen         = doen_q;
    assign left         = left_q;
    assign right        = right_q;
    assign sample_valid = valid_q;
    assign frame_err    = ferr_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_jtdsp16_sout_deser.sv
// Directed bench for jtdsp16_sout_deser: one MSB-first and one LSB-first receiver share the
// same serial stream and handshake; expected values are hand-computed constants.
module tb_jtdsp16_sout_deser;

    localparam int TIMEOUT = 64;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        sdo;
    logic        ock;
    logic        old;
    logic        sadd;
    logic        sample_ack;

    logic        doen0, doen1;
    logic [15:0] left0, left1, right0, right1;
    logic        sv0, sv1, fe0, fe1, ov0, ov1;

    int compared   = 0;
    int mismatched = 0;

    jtdsp16_sout_deser #(.MSB_FIRST(1), .TIMEOUT(TIMEOUT)) u0 (
        .clk(clk), .rst(rst), .enable(enable), .sdo(sdo), .ock(ock), .old(old), .sadd(sadd),
        .doen(doen0), .left(left0), .right(right0), .sample_valid(sv0),
        .sample_ack(sample_ack), .frame_err(fe0), .overrun(ov0)
    );

    jtdsp16_sout_deser #(.MSB_FIRST(0), .TIMEOUT(TIMEOUT)) u1 (
        .clk(clk), .rst(rst), .enable(enable), .sdo(sdo), .ock(ock), .old(old), .sadd(sadd),
        .doen(doen1), .left(left1), .right(right1), .sample_valid(sv1),
        .sample_ack(sample_ack), .frame_err(fe1), .overrun(ov1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sdo = b;
        tick(2);
        ock = 1'b1;
        tick(2);
        ock = 1'b0;
        tick(2);
    endtask

    task automatic start_word(input logic ch);
        sadd = ch;
        old  = 1'b1;
        tick(2);
        old  = 1'b0;
        tick(2);
    endtask

    // bits go out w[15] first; the LSB-first receiver therefore sees the bit-reversed word
    task automatic send_word(input logic ch, input logic [15:0] w);
        start_word(ch);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
        tick(2);
    endtask

    task automatic pulse_ack();
        sample_ack = 1'b1;
        tick(1);
        sample_ack = 1'b0;
        tick(1);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; enable = 1'b1;
        sdo = 1'b0; ock = 1'b0; old = 1'b0; sadd = 1'b0; sample_ack = 1'b0;

        tick(2);
        check("rst_doen",  doen0, 16'h0);
        check("rst_doen1", doen1, 16'h0);
        check("rst_left",  left0, 16'h0);
        check("rst_right", right0, 16'h0);
        check("rst_valid", sv0, 16'h0);
        check("rst_ferr",  fe0, 16'h0);
        check("rst_ovr",   ov0, 16'h0);
        rst = 1'b0;
        tick(2);
        check("doen_on", doen0, 16'h1);

        // 1: basic pair, no ack
        send_word(1'b1, 16'h8001);
        send_word(1'b0, 16'h7FFE);
        check("t1_valid", sv0, 16'h1);
        check("t1_left",  left0, 16'h8001);
        check("t1_right", right0, 16'h7FFE);
        check("t1_ovr",   ov0, 16'h0);

        // 2: second pair while first is unacked -> overrun
        send_word(1'b1, 16'h1234);
        send_word(1'b0, 16'h5678);
        check("t2_ovr",   ov0, 16'h1);
        check("t2_left",  left0, 16'h8001);
        check("t2_right", right0, 16'h7FFE);
        check("t2_valid", sv0, 16'h1);
        pulse_ack();
        check("t2_ack_valid", sv0, 16'h0);
        check("t2_ack_ovr",   ov0, 16'h0);

        // 3: ock stalls after 7 bits -> timeout abort
        start_word(1'b1);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        tick(TIMEOUT + 6);
        check("t3_ferr",  fe0, 16'h1);
        check("t3_valid", sv0, 16'h0);
        send_word(1'b1, 16'hA5A5);
        send_word(1'b0, 16'h5A5A);
        check("t3_valid2", sv0, 16'h1);
        check("t3_left",   left0, 16'hA5A5);
        check("t3_right",  right0, 16'h5A5A);
        check("t3_ferr_held", fe0, 16'h1);
        pulse_ack();
        check("t3_ack_ferr",  fe0, 16'h0);
        check("t3_ack_valid", sv0, 16'h0);

        // 4: orphan right dropped; second left overwrites first
        send_word(1'b0, 16'h4444);
        check("t4_orphan_valid", sv0, 16'h0);
        check("t4_orphan_ferr",  fe0, 16'h0);
        check("t4_orphan_ovr",   ov0, 16'h0);
        send_word(1'b1, 16'h1111);
        send_word(1'b1, 16'h2222);
        send_word(1'b0, 16'h3333);
        check("t4_valid", sv0, 16'h1);
        check("t4_left",  left0, 16'h2222);
        check("t4_right", right0, 16'h3333);
        pulse_ack();

        // 5: stream 1,0,...,0 -> 0x8000 MSB-first, 0x0001 LSB-first
        send_word(1'b1, 16'h8000);
        send_word(1'b0, 16'h8000);
        check("t5_msb_left",  left0, 16'h8000);
        check("t5_msb_right", right0, 16'h8000);
        check("t5_lsb_left",  left1, 16'h0001);
        check("t5_lsb_right", right1, 16'h0001);
        check("t5_lsb_valid", sv1, 16'h1);
        check("t5_lsb_flags", {fe1, ov1}, 16'h0);
        pulse_ack();

        // enable drop discards the pending left word without flags
        send_word(1'b1, 16'hAAAA);
        enable = 1'b0;
        tick(3);
        check("en_doen", doen0, 16'h0);
        enable = 1'b1;
        tick(3);
        send_word(1'b0, 16'hBBBB);
        check("en_valid", sv0, 16'h0);
        check("en_flags", {fe0, ov0}, 16'h0);

        // 6: reset mid-word, then reset with a pair valid
        start_word(1'b1);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        rst = 1'b1;
        #1;
        check("t6_shift_doen", doen0, 16'h0);
        tick(2);
        rst = 1'b0;
        tick(2);
        send_word(1'b1, 16'h1357);
        send_word(1'b0, 16'h2468);
        check("t6_pre_valid", sv0, 16'h1);
        check("t6_pre_left",  left0, 16'h1357);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", sv0, 16'h0);
        check("t6_rst_left",  left0, 16'h0);
        check("t6_rst_right", right0, 16'h0);
        check("t6_rst_doen",  doen0, 16'h0);
        tick(2);
        rst = 1'b0;
        tick(2);
        send_word(1'b1, 16'h0F0F);
        send_word(1'b0, 16'hF0F0);
        check("t6_post_valid", sv0, 16'h1);
        check("t6_post_left",  left0, 16'h0F0F);
        check("t6_post_right", right0, 16'hF0F0);
        check("t6_post_flags", {fe0, ov0}, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
